triangle_check_master: RTL and testbench

Avalon-MM master that drives the triangle-check slave in place of software. It accepts side-length triplets on a valid/ready input stream and writes A, B and C to slave addresses 0, 1 and 2. It then reads the result at address 3 and returns a one-bit verdict, with an error flag, on a valid/ready output stream. Running counters of total and triangle verdicts are kept for status readout.

---
 rtl/triangle_check_master.sv | 176 +++++++++++++++++
 tb/tb_triangle_check_master.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_check_master.sv
// triangle_check_master: Avalon-MM master that writes side lengths A/B/C to
// the triangle-check slave (addr 0/1/2), reads the verdict (addr 3) and
// streams it out with an error flag; keeps running verdict counters.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   in_valid/in_ready, in_a/b/c     input triplet stream
//   avm_address/read/write/
//     writedata/waitrequest/readdata Avalon-MM master port
//   out_valid/out_ready,
//     out_is_triangle/out_error     verdict stream
//   total_count, tri_count, busy    status
module triangle_check_master #(
    parameter int READ_LATENCY  = 1,
    parameter int SETTLE_CYCLES = 0,
    parameter int TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_c,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_is_triangle,
    output logic        out_error,
    output logic [31:0] total_count,
    output logic [31:0] tri_count,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, WR_A, WR_B, WR_C, SETTLE, RD_RES, RD_WAIT, OUT
    } state_t;

    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  RD_LAST     = 4'(READ_LATENCY - 1);
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      nxt;
    logic [31:0] b_q;
    logic [31:0] c_q;
    logic [15:0] to_cnt;
    logic [3:0]  w_cnt;

    logic in_hs;
    logic out_hs;
    logic cmd_state;
    logic to_hit;
    logic sample;
    logic unused_rd;

    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign cmd_state = state inside {WR_A, WR_B, WR_C, RD_RES};
    assign unused_rd = ^avm_readdata[31:1];

    // Abort fires on the stalled cycle that brings the count to TIMEOUT;
    // a cycle with waitrequest low never aborts, so acceptance wins.
    assign to_hit = (TIMEOUT != 0) && cmd_state && avm_waitrequest &&
                    (to_cnt == TO_LAST);

    assign sample = (state == RD_RES && !avm_waitrequest &&
                     READ_LATENCY == 0) ||
                    (state == RD_WAIT && w_cnt == RD_LAST);

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (in_hs) nxt = WR_A;
            WR_A:    if (!avm_waitrequest) nxt = WR_B;
                     else if (to_hit) nxt = OUT;
            WR_B:    if (!avm_waitrequest) nxt = WR_C;
                     else if (to_hit) nxt = OUT;
            WR_C:    if (!avm_waitrequest)
                         nxt = (SETTLE_CYCLES > 0) ? SETTLE : RD_RES;
                     else if (to_hit) nxt = OUT;
            SETTLE:  if (w_cnt == SETTLE_LAST) nxt = RD_RES;
            RD_RES:  if (!avm_waitrequest)
                         nxt = (READ_LATENCY == 0) ? OUT : RD_WAIT;
                     else if (to_hit) nxt = OUT;
            RD_WAIT: if (w_cnt == RD_LAST) nxt = OUT;
            OUT:     if (out_hs) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // All outputs are registered from the next state, so nothing on the
    // input side reaches an output without passing a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            in_ready        <= 1'b0;
            busy            <= 1'b0;
            avm_read        <= 1'b0;
            avm_write       <= 1'b0;
            avm_address     <= 2'd0;
            avm_writedata   <= 32'd0;
            out_valid       <= 1'b0;
            out_is_triangle <= 1'b0;
            out_error       <= 1'b0;
            total_count     <= 32'd0;
            tri_count       <= 32'd0;
            b_q             <= 32'd0;
            c_q             <= 32'd0;
            to_cnt          <= 16'd0;
            w_cnt           <= 4'd0;
        end else begin
            state     <= nxt;
            in_ready  <= (nxt == IDLE);
            busy      <= (nxt != IDLE);
            avm_write <= nxt inside {WR_A, WR_B, WR_C};
            avm_read  <= (nxt == RD_RES);
            out_valid <= (nxt == OUT);

            unique case (nxt)
                WR_A: begin
                    avm_address   <= 2'd0;
                    avm_writedata <= in_hs ? in_a : avm_writedata;
                end
                WR_B: begin
                    avm_address   <= 2'd1;
                    avm_writedata <= b_q;
                end
                WR_C: begin
                    avm_address   <= 2'd2;
                    avm_writedata <= c_q;
                end
                RD_RES: begin
                    avm_address   <= 2'd3;
                    avm_writedata <= 32'd0;
                end
                default: begin
                    avm_address   <= 2'd0;
                    avm_writedata <= 32'd0;
                end
            endcase

            if (in_hs) begin
                b_q <= in_b;
                c_q <= in_c;
            end

            if (nxt != state) to_cnt <= 16'd0;
            else if (cmd_state && avm_waitrequest) to_cnt <= to_cnt + 16'd1;

            if (nxt != state) w_cnt <= 4'd0;
            else if (state == SETTLE || state == RD_WAIT) w_cnt <= w_cnt + 4'd1;

            if (sample) begin
                out_is_triangle <= avm_readdata[0];
                out_error       <= 1'b0;
            end else if (to_hit) begin
                out_is_triangle <= 1'b0;
                out_error       <= 1'b1;
            end else if (out_hs) begin
                out_is_triangle <= 1'b0;
                out_error       <= 1'b0;
            end

            if (out_hs) begin
                total_count <= total_count + 32'd1;
                tri_count   <= tri_count + {31'd0, out_is_triangle};
            end
        end
    end

endmodule

// File: tb/tb_triangle_check_master.sv
// Testbench for triangle_check_master: two instances (RL=1/S=0/TO=8 and
// RL=0/S=3/TO=0) against a behavioural Avalon slave and verdict model.
module tb_triangle_check_master;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       in_valid, in_ready;
    logic [1:0][31:0] in_a, in_b, in_c;
    logic [1:0][1:0]  avm_address;
    logic [1:0]       avm_read, avm_write, avm_waitrequest;
    logic [1:0][31:0] avm_writedata, avm_readdata;
    logic [1:0]       out_valid, out_ready, out_is_triangle, out_error, busy;
    logic [1:0][31:0] total_count, tri_count;

    int errors = 0;
    int checks = 0;
    int exp_total[2] = '{0, 0};
    int exp_tri[2] = '{0, 0};

    // slave model state
    int          wmode[2] = '{0, 0};
    logic [1:0]  seen;
    int          rd_age[2];
    logic [1:0]  last_rd_addr[2];
    logic [31:0] mem[2][4];
    int          prot_err[2] = '{0, 0};
    logic [1:0]  prev_stall;
    logic [35:0] prev_cmd[2];

    function automatic int rl_of(input int g);
        return (g == 0) ? 1 : 0;
    endfunction

    function automatic int settle_of(input int g);
        return (g == 0) ? 0 : 3;
    endfunction

    function automatic logic tri_fn(input logic [31:0] a, b, c);
        logic [32:0] ab, ac, bc;
        ab = {1'b0, a} + {1'b0, b};
        ac = {1'b0, a} + {1'b0, c};
        bc = {1'b0, b} + {1'b0, c};
        return (ab > {1'b0, c}) && (ac > {1'b0, b}) && (bc > {1'b0, a});
    endfunction

    // Cycles from handshake to first out_valid: four commands, settle gap,
    // read latency, then the output cycle itself.
    function automatic int exp_lat(input int s, input int m);
        return 4 * ((m == 1) ? 2 : 1) + settle_of(s) + rl_of(s) + 1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        triangle_check_master #(
            .READ_LATENCY (g == 0 ? 1 : 0),
            .SETTLE_CYCLES(g == 0 ? 0 : 3),
            .TIMEOUT      (g == 0 ? 8 : 0)
        ) dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .in_valid       (in_valid[g]),
            .in_ready       (in_ready[g]),
            .in_a           (in_a[g]),
            .in_b           (in_b[g]),
            .in_c           (in_c[g]),
            .avm_address    (avm_address[g]),
            .avm_read       (avm_read[g]),
            .avm_write      (avm_write[g]),
            .avm_writedata  (avm_writedata[g]),
            .avm_waitrequest(avm_waitrequest[g]),
            .avm_readdata   (avm_readdata[g]),
            .out_valid      (out_valid[g]),
            .out_ready      (out_ready[g]),
            .out_is_triangle(out_is_triangle[g]),
            .out_error      (out_error[g]),
            .total_count    (total_count[g]),
            .tri_count      (tri_count[g]),
            .busy           (busy[g])
        );
    end

    // Slave: mode 0 zero-wait, mode 1 stalls first cycle of each command,
    // mode 2 stalls writes to addr 1 forever. Readdata bit 0 carries the
    // verdict only at the cycle the master is meant to sample it.
    always_comb begin : slave_comb
        logic r;
        logic v;
        r = 1'b0;
        v = 1'b0;
        avm_waitrequest = '0;
        avm_readdata = '0;
        for (int g = 0; g < 2; g++) begin
            if (wmode[g] == 1)
                avm_waitrequest[g] = (avm_read[g] | avm_write[g]) & ~seen[g];
            else if (wmode[g] == 2)
                avm_waitrequest[g] = avm_write[g] && avm_address[g] == 2'd1;
            r = tri_fn(mem[g][0], mem[g][1], mem[g][2]);
            if (rl_of(g) == 0) v = avm_read[g] && !avm_waitrequest[g];
            else v = (rd_age[g] == rl_of(g));
            avm_readdata[g] = {31'h2AAAAAAA, v ? r : ~r};
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen <= '0;
            prev_stall <= '0;
            rd_age <= '{0, 0};
        end else begin
            for (int g = 0; g < 2; g++) begin
                seen[g] <= (avm_read[g] | avm_write[g]) & avm_waitrequest[g];
                if (avm_read[g] && !avm_waitrequest[g]) begin
                    rd_age[g] <= 1;
                    last_rd_addr[g] <= avm_address[g];
                end else if (rd_age[g] != 0 && rd_age[g] < 15) begin
                    rd_age[g] <= rd_age[g] + 1;
                end
                if (avm_write[g] && !avm_waitrequest[g])
                    mem[g][avm_address[g]] <= avm_writedata[g];
                if ((avm_read[g] && avm_write[g]) ||
                    (prev_stall[g] && (avm_read[g] | avm_write[g]) &&
                     prev_cmd[g] != {avm_read[g], avm_write[g],
                                     avm_address[g], avm_writedata[g]}))
                    prot_err[g] <= prot_err[g] + 1;
                prev_stall[g] <= (avm_read[g] | avm_write[g]) & avm_waitrequest[g];
                prev_cmd[g] <= {avm_read[g], avm_write[g],
                                avm_address[g], avm_writedata[g]};
            end
        end
    end

    task automatic launch(input int s, input logic [31:0] a, b, c);
        int n;
        n = 0;
        in_valid[s] = 1'b1;
        in_a[s] = a;
        in_b[s] = b;
        in_c[s] = c;
        while (!in_ready[s] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready[s] !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_wait[%0d]: got %b expected 1", s, in_ready[s]);
        end
        @(posedge clk); #1;
        in_valid[s] = 1'b0;
    endtask

    task automatic complete(input int s, input logic [31:0] a, b, c,
                            input int lat_exp, input logic err_exp,
                            input int idle_exp);
        int lat;
        int idle;
        logic t_exp;
        lat = 1;
        idle = 0;
        while (!out_valid[s] && lat < 100) begin
            if (busy[s] && !avm_read[s] && !avm_write[s]) idle++;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== lat_exp) begin
            errors++;
            $display("FAIL latency[%0d]: got %0d expected %0d", s, lat, lat_exp);
        end
        checks++;
        if (idle !== idle_exp) begin
            errors++;
            $display("FAIL idle_cycles[%0d]: got %0d expected %0d", s, idle, idle_exp);
        end
        t_exp = err_exp ? 1'b0 : tri_fn(a, b, c);
        checks++;
        if (out_is_triangle[s] !== t_exp) begin
            errors++;
            $display("FAIL verdict[%0d] (%0d,%0d,%0d): got %b expected %b",
                     s, a, b, c, out_is_triangle[s], t_exp);
        end
        checks++;
        if (out_error[s] !== err_exp) begin
            errors++;
            $display("FAIL out_error[%0d]: got %b expected %b", s, out_error[s], err_exp);
        end
        checks++;
        if ({avm_read[s], avm_write[s]} !== 2'b00) begin
            errors++;
            $display("FAIL cmd_in_out[%0d]: got %b expected 00", s,
                     {avm_read[s], avm_write[s]});
        end
        if (!err_exp) begin
            checks++;
            if ({mem[s][0], mem[s][1], mem[s][2]} !== {a, b, c}) begin
                errors++;
                $display("FAIL writes[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         s, mem[s][0], mem[s][1], mem[s][2], a, b, c);
            end
            checks++;
            if (last_rd_addr[s] !== 2'd3) begin
                errors++;
                $display("FAIL read_addr[%0d]: got %0d expected 3", s, last_rd_addr[s]);
            end
        end
        @(posedge clk); #1;
        exp_total[s]++;
        if (t_exp) exp_tri[s]++;
        checks++;
        if (total_count[s] !== 32'(exp_total[s]) || tri_count[s] !== 32'(exp_tri[s])) begin
            errors++;
            $display("FAIL counters[%0d]: got %0d/%0d expected %0d/%0d", s,
                     total_count[s], tri_count[s], exp_total[s], exp_tri[s]);
        end
        checks++;
        if ({out_valid[s], in_ready[s], busy[s]} !== 3'b010) begin
            errors++;
            $display("FAIL back_idle[%0d]: got %b expected 010", s,
                     {out_valid[s], in_ready[s], busy[s]});
        end
    endtask

    task automatic test_reset();
        #12;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({in_ready[g], avm_read[g], avm_write[g], avm_address[g],
                 avm_writedata[g], out_valid[g], out_is_triangle[g],
                 out_error[g], busy[g]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got nonzero expected 0", g);
            end
            checks++;
            if ({total_count[g], tri_count[g]} !== 64'd0) begin
                errors++;
                $display("FAIL reset_counters[%0d]: got %0d/%0d expected 0/0",
                         g, total_count[g], tri_count[g]);
            end
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_pre_clock: got %b expected 0", in_ready[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 2'b11) begin
            errors++;
            $display("FAIL in_ready_first_clock: got %b expected 11", in_ready);
        end
    endtask

    task automatic test_basic();
        wmode[0] = 0;
        launch(0, 3, 4, 5);
        complete(0, 3, 4, 5, 6, 1'b0, 1);
        launch(0, 1, 2, 3);
        complete(0, 1, 2, 3, 6, 1'b0, 1);
    endtask

    task automatic test_wait_slave();
        wmode[0] = 1;
        launch(0, 1, 2, 3);
        complete(0, 1, 2, 3, 10, 1'b0, 1);
        wmode[0] = 0;
    endtask

    task automatic test_timeout();
        wmode[0] = 2;
        launch(0, 10, 11, 12);
        complete(0, 10, 11, 12, 10, 1'b1, 0);
        wmode[0] = 0;
    endtask

    task automatic test_backpressure();
        int n;
        logic v0;
        n = 0;
        out_ready[0] = 1'b0;
        launch(0, 3, 4, 5);
        while (!out_valid[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid[0] = 1'b1;
        in_a[0] = 6;
        in_b[0] = 8;
        in_c[0] = 10;
        v0 = out_is_triangle[0];
        checks++;
        if (v0 !== 1'b1) begin
            errors++;
            $display("FAIL bp_verdict: got %b expected 1", v0);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({in_ready[0], out_valid[0], out_is_triangle[0]} !== {2'b01, v0}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got %b expected %b", i,
                         {in_ready[0], out_valid[0], out_is_triangle[0]}, {2'b01, v0});
            end
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        exp_total[0]++;
        exp_tri[0]++;
        checks++;
        if ({in_ready[0], out_valid[0]} !== 2'b10 ||
            total_count[0] !== 32'(exp_total[0])) begin
            errors++;
            $display("FAIL bp_release: got rdy/vld %b total %0d expected 10 total %0d",
                     {in_ready[0], out_valid[0]}, total_count[0], exp_total[0]);
        end
        launch(0, 6, 8, 10);
        complete(0, 6, 8, 10, 6, 1'b0, 1);
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        launch(0, 7, 8, 9);
        while (!avm_read[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        exp_total = '{0, 0};
        exp_tri = '{0, 0};
        checks++;
        if ({avm_read[0], busy[0], out_valid[0]} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b expected 000",
                     {avm_read[0], busy[0], out_valid[0]});
        end
        checks++;
        if ({total_count, tri_count} !== '0) begin
            errors++;
            $display("FAIL mid_reset_counters: got %0d/%0d expected 0/0",
                     total_count[0], tri_count[0]);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        launch(0, 7, 8, 9);
        complete(0, 7, 8, 9, 6, 1'b0, 1);
    endtask

    task automatic test_settle();
        wmode[1] = 0;
        launch(1, 5, 5, 9);
        complete(1, 5, 5, 9, 8, 1'b0, 3);
    endtask

    task automatic test_random();
        int s;
        int m;
        logic [31:0] a, b, c;
        for (int i = 0; i < 30; i++) begin
            s = $urandom_range(0, 1);
            m = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom();
                b = $urandom();
                c = $urandom();
            end else begin
                a = $urandom_range(1, 12);
                b = $urandom_range(1, 12);
                c = $urandom_range(1, 12);
            end
            wmode[s] = m;
            launch(s, a, b, c);
            complete(s, a, b, c, exp_lat(s, m), 1'b0, settle_of(s) + rl_of(s));
            wmode[s] = 0;
        end
    endtask

    task automatic test_protocol();
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (prot_err[g] !== 0) begin
                errors++;
                $display("FAIL protocol[%0d]: got %0d violations expected 0",
                         g, prot_err[g]);
            end
        end
    endtask

    initial begin
        in_valid = '0;
        out_ready = '1;
        in_a = '0;
        in_b = '0;
        in_c = '0;
        test_reset();
        test_basic();
        test_wait_slave();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_settle();
        test_random();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
